instr_decoder: RTL and testbench

Downstream stage of the instruction FIFO. Accepts 64-bit instructions over a valid/ready handshake, decodes them and issues one command per instruction to the systolic-array datapath. Tracks outstanding commands so SYNC can enforce ordering. Flags illegal opcodes and stops on HALT.

---
 rtl/instr_decoder.sv | 149 ++++++++++++++
 tb/tb_instr_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decoder.sv
// Instruction decoder: takes 64-bit instructions from the FIFO and issues
// one command per instruction to the systolic-array datapath.
module instr_decoder #(
    parameter int MAX_OUT = 4,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       instr_in,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_len,
    input  logic              op_done,
    output logic              busy,
    output logic              halted,
    output logic              err_illegal,
    output logic [15:0]       retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SYNC,
        S_HALTED
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    state_t              state_q, state_d;
    logic [3:0]          out_q, out_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [1:0]          cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [7:0]          cmd_len_q, cmd_len_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;
    logic [15:0]         retired_q, retired_d;

    logic       accept;
    logic       cmd_hs;
    logic [3:0] opcode;
    logic       unused_rsvd;

    assign opcode      = instr_in[63:60];
    assign unused_rsvd = ^instr_in[35:0];
    assign instr_ready = !rst && (state_q == S_IDLE) && (out_q < MAX_CNT);
    assign accept      = instr_valid && instr_ready;
    assign cmd_hs      = cmd_valid_q && cmd_ready;

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        cmd_op_d   = cmd_op_q;
        cmd_addr_d = cmd_addr_q;
        cmd_len_d  = cmd_len_q;
        halted_d   = halted_q;
        err_d      = err_q;
        retired_d  = retired_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    unique case (opcode)
                        4'd0: retired_d = retired_q + 16'd1;
                        4'd1, 4'd2, 4'd3, 4'd4: begin
                            // opcodes 1..4 map onto cmd_op 0..3
                            cmd_op_d   = opcode[1:0] - 2'd1;
                            cmd_addr_d = instr_in[59:44];
                            cmd_len_d  = instr_in[43:36];
                            state_d    = S_ISSUE;
                        end
                        4'd5: begin
                            retired_d = retired_q + 16'd1;
                            state_d   = S_WAIT_SYNC;
                        end
                        4'd15: begin
                            retired_d = retired_q + 16'd1;
                            halted_d  = 1'b1;
                            state_d   = S_HALTED;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ISSUE: begin
                if (cmd_hs) begin
                    retired_d = retired_q + 16'd1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_SYNC: begin
                if (out_q == 4'd0) state_d = S_IDLE;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        // a completion with nothing outstanding is ignored
        if (cmd_hs && !op_done) begin
            out_d = out_q + 4'd1;
        end else if (!cmd_hs && op_done && out_q != 4'd0) begin
            out_d = out_q - 4'd1;
        end

        cmd_valid_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE) || (out_d != 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_q       <= 4'd0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= 2'd0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= 8'd0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            retired_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_len_q   <= cmd_len_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
            retired_q   <= retired_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_addr    = cmd_addr_q;
    assign cmd_len     = cmd_len_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign err_illegal = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: expected commands are queued at
// issue time and popped by a monitor on every command handshake.
module tb_instr_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        op_done;
    logic        busy;
    logic        halted;
    logic        err_illegal;
    logic [15:0] retired;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [7:0]  len;
    } cmd_t;

    cmd_t exp_q[$];

    instr_decoder #(.MAX_OUT(4), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .op_done(op_done), .busy(busy), .halted(halted),
        .err_illegal(err_illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest expected command
    always @(negedge clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_cmd", 32'(cmd_op), 32'hDEAD);
            end else begin
                cmd_t e;
                e = exp_q.pop_front();
                chk("cmd_op", 32'(cmd_op), 32'(e.op));
                chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
                chk("cmd_len", 32'(cmd_len), 32'(e.len));
            end
        end
    end

    function automatic logic [63:0] mk(input logic [3:0] op,
                                       input logic [15:0] addr,
                                       input logic [7:0] len);
        return {op, addr, len, 36'h5A5A5A5A5};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
    endtask

    // Present an instruction and hold it until accepted (bounded)
    task automatic send(input logic [63:0] ins);
        bit ok = 1'b0;
        instr_in    = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        instr_valid = 1'b0;
    endtask

    // Send a datapath command, check decode latency, complete handshake
    task automatic issue(input logic [3:0] op, input logic [15:0] addr,
                         input logic [7:0] len, input logic od);
        cmd_t e;
        e.op   = op[1:0] - 2'd1;
        e.addr = addr;
        e.len  = len;
        exp_q.push_back(e);
        send(mk(op, addr, len));
        chk("cmd_valid_latency", 32'(cmd_valid), 32'd1);
        op_done = od;
        tick();
        op_done = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        instr_in    = '0;
        instr_valid = 1'b0;
        cmd_ready   = 1'b1;
        op_done     = 1'b0;
        tick();
        tick();
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_flags", {busy, halted, err_illegal}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(instr_ready), 32'd1);

        // single LOAD_A
        issue(4'd1, 16'h0100, 8'd16, 1'b0);
        chk("t1_retired", 32'(retired), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        pulse_done();
        chk("t1_idle", 32'(busy), 32'd0);

        // STORE stalled by cmd_ready=0
        cmd_ready = 1'b0;
        exp_q.push_back('{op: 2'd3, addr: 16'hBEEF, len: 8'h20});
        send(mk(4'd4, 16'hBEEF, 8'h20));
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(cmd_valid), 32'd1);
            chk("stall_fields", {6'd0, cmd_op, cmd_addr, cmd_len},
                {6'd0, 2'd3, 16'hBEEF, 8'h20});
            chk("stall_ready", 32'(instr_ready), 32'd0);
            chk("stall_retired", 32'(retired), 32'd1);
            tick();
        end
        cmd_ready = 1'b1;
        tick();
        chk("t2_retired", 32'(retired), 32'd2);
        pulse_done();

        // fill to MAX_OUT
        issue(4'd2, 16'h0200, 8'd1, 1'b0);
        issue(4'd3, 16'h0300, 8'd2, 1'b0);
        issue(4'd1, 16'h0400, 8'd3, 1'b0);
        issue(4'd4, 16'h0500, 8'd4, 1'b0);
        chk("full_ready", 32'(instr_ready), 32'd0);
        chk("t3_retired", 32'(retired), 32'd6);
        pulse_done();
        chk("one_free_ready", 32'(instr_ready), 32'd1);
        // completion coincides with handshake: count stays at 3
        issue(4'd2, 16'h0600, 8'd5, 1'b1);
        chk("coincide_ready", 32'(instr_ready), 32'd1);
        chk("t3b_retired", 32'(retired), 32'd7);
        pulse_done();
        pulse_done();
        pulse_done();
        chk("drain_busy", 32'(busy), 32'd0);

        // SYNC after three commands
        issue(4'd1, 16'h1000, 8'd8, 1'b0);
        issue(4'd2, 16'h2000, 8'd8, 1'b0);
        issue(4'd3, 16'h3000, 8'd8, 1'b0);
        send(mk(4'd5, 16'h0, 8'h0));
        chk("sync_retired", 32'(retired), 32'd11);
        chk("sync_block", 32'(instr_ready), 32'd0);
        pulse_done();
        pulse_done();
        chk("sync_block2", 32'(instr_ready), 32'd0);
        pulse_done();
        chk("sync_last_done", 32'(instr_ready), 32'd0);
        tick();
        chk("sync_release", 32'(instr_ready), 32'd1);
        chk("sync_busy", 32'(busy), 32'd0);
        pulse_done();
        chk("no_underflow", 32'(instr_ready), 32'd1);

        // illegal, NOP, HALT
        send(mk(4'd7, 16'hFFFF, 8'hFF));
        chk("illegal_err", 32'(err_illegal), 32'd1);
        chk("illegal_retired", 32'(retired), 32'd11);
        send(mk(4'd0, 16'h0, 8'h0));
        chk("nop_retired", 32'(retired), 32'd12);
        send(mk(4'd15, 16'h0, 8'h0));
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_retired", 32'(retired), 32'd13);
        instr_in    = mk(4'd0, 16'h0, 8'h0);
        instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("halt_ready", 32'(instr_ready), 32'd0);
            tick();
        end
        instr_valid = 1'b0;
        chk("halt_hold_retired", 32'(retired), 32'd13);
        chk("err_sticky", 32'(err_illegal), 32'd1);
        chk("halt_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_clears", {retired, 13'd0, busy, halted, err_illegal},
            32'd0);
        tick();
        rst = 1'b0;

        // reset during ISSUE drops the command
        tick();
        cmd_ready = 1'b0;
        send(mk(4'd2, 16'hAAAA, 8'h11));
        chk("pre_rst_valid", 32'(cmd_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(cmd_valid), 32'd0);
        chk("rst_mid_fields", {6'd0, cmd_op, cmd_addr, cmd_len}, 32'd0);
        chk("rst_mid_ready", 32'(instr_ready), 32'd0);
        chk("rst_mid_flags", {retired, 13'd0, busy, halted, err_illegal},
            32'd0);
        tick();
        rst = 1'b0;
        cmd_ready = 1'b1;
        tick();
        issue(4'd3, 16'h1234, 8'hFF, 1'b0);
        chk("resume_retired", 32'(retired), 32'd1);

        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
